// File: rtl/am_demodulator.sv
// Coherent AM demodulator: carrier mix, N-tap boxcar low-pass, x2 rescale,
// DC-offset removal and saturation to Q1.FW, with a post-reset fill indicator.
module am_demodulator #(
  parameter int DW    = 12,
  parameter int LOG2N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [DW-1:0] carr,
  input  logic signed [DW:0]   modin,
  input  logic signed [DW-1:0] shift,
  output logic signed [DW-1:0] dout,
  output logic                 dout_valid
);

  localparam int N  = 1 << LOG2N;
  localparam int AW = DW + 1 + LOG2N;
  localparam int XW = DW + LOG2N + 2;
  localparam int CW = LOG2N + 2;

  localparam logic signed [XW-1:0] SAT_HI   = XW'((1 << (DW-1)) - 1);
  localparam logic signed [XW-1:0] SAT_LO   = ~SAT_HI;
  localparam logic [CW-1:0]        FILL_MAX = CW'(N + 3);
  localparam logic [CW-1:0]        FILL_VLD = CW'(N + 2);

  logic signed [2*DW:0]  prod_q;
  logic signed [DW:0]    mix_q;
  logic signed [DW:0]    win_q [N];
  logic [LOG2N-1:0]      wr_ptr_q;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [XW-1:0]  diff_d;
  logic signed [DW-1:0]  dout_q, dout_d;
  logic [CW-1:0]         fill_q, fill_d;
  logic                  valid_q, valid_d;
  logic signed [DW:0]    oldest;

  // Only the Q2.FW window of the product is kept; the rest is deliberately dropped.
  logic unused_prod_bits;
  assign unused_prod_bits = ^{prod_q[2*DW], prod_q[DW-2:0]};

  assign oldest = win_q[wr_ptr_q];

  always_comb begin
    acc_d = acc_q + {{LOG2N{mix_q[DW]}}, mix_q} - {{LOG2N{oldest[DW]}}, oldest};

    // acc/2^(LOG2N-1) is twice the window mean.
    diff_d = XW'(acc_q >>> (LOG2N-1)) - XW'(shift);
    if (diff_d > SAT_HI)
      dout_d = SAT_HI[DW-1:0];
    else if (diff_d < SAT_LO)
      dout_d = SAT_LO[DW-1:0];
    else
      dout_d = diff_d[DW-1:0];

    fill_d  = (fill_q == FILL_MAX) ? fill_q : fill_q + CW'(1);
    valid_d = valid_q | (fill_q >= FILL_VLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q   <= '0;
      mix_q    <= '0;
      for (int i = 0; i < N; i++) win_q[i] <= '0;
      wr_ptr_q <= '0;
      acc_q    <= '0;
      dout_q   <= '0;
      fill_q   <= '0;
      valid_q  <= 1'b0;
    end else if (en) begin
      prod_q          <= modin * carr;
      mix_q           <= prod_q[2*DW-1:DW-1];
      win_q[wr_ptr_q] <= mix_q;
      wr_ptr_q        <= wr_ptr_q + LOG2N'(1);
      acc_q           <= acc_d;
      dout_q          <= dout_d;
      fill_q          <= fill_d;
      valid_q         <= valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;

endmodule

// File: tb/tb_am_demodulator.sv
// Self-checking bench for am_demodulator: directed plan scenarios plus random
// traffic, compared against a sample-history model of the boxcar demodulator.
module tb_am_demodulator;

  localparam int DW    = 12;
  localparam int LOG2N = 4;
  localparam int N     = 1 << LOG2N;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en  = 1'b0;
  logic signed [DW-1:0] carr  = '0;
  logic signed [DW:0]   modin = '0;
  logic signed [DW-1:0] shift = '0;
  logic signed [DW-1:0] dout;
  logic                 dout_valid;

  int     n_chk = 0;
  int     n_bad = 0;
  int     e     = 0;
  longint hist[$];
  longint exp_dout  = 0;
  longint exp_valid = 0;

  am_demodulator #(.DW(DW), .LOG2N(LOG2N)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .carr       (carr),
    .modin      (modin),
    .shift      (shift),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint expv);
    n_chk++;
    if (obs != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, expv, e);
    end
  endtask

  // Product floored to Q2.FW, then wrapped into DW+1 signed bits.
  function automatic longint mix_of(input longint m, input longint c);
    longint p;
    longint f;
    logic signed [DW:0] w;
    p = m * c;
    f = p >>> (DW - 1);
    w = f[DW:0];
    return longint'(w);
  endfunction

  task automatic step(input string tag, input bit r, input bit en_v,
                      input longint m, input longint c, input longint s);
    longint sum;
    longint d;
    @(negedge clk);
    rst   = r;
    en    = en_v;
    modin = m[DW:0];
    carr  = c[DW-1:0];
    shift = s[DW-1:0];
    @(posedge clk);
    if (r) begin
      e = 0;
      hist.delete();
      exp_dout  = 0;
      exp_valid = 0;
    end else if (en_v) begin
      e++;
      hist.push_back(mix_of(m, c));
      sum = 0;
      for (int k = e - N - 2; k <= e - 3; k++)
        if (k >= 1) sum += hist[k-1];
      d = (sum >>> (LOG2N - 1)) - s;
      if (d > 2047) d = 2047;
      if (d < -2048) d = -2048;
      exp_dout  = d;
      exp_valid = (e >= N + 3) ? 1 : 0;
    end
    #1;
    check({tag, "_dout"}, longint'(dout), exp_dout);
    check({tag, "_valid"}, longint'(dout_valid), exp_valid);
  endtask

  function automatic longint rnd_s(input int bits);
    return longint'($urandom_range(0, (1 << bits) - 1)) - (longint'(1) << (bits - 1));
  endfunction

  initial begin
    longint sh;

    for (int i = 0; i < 3; i++)
      step("reset", 1'b1, 1'($urandom % 2), rnd_s(DW+1), rnd_s(DW), rnd_s(DW));

    // DC carrier with a 5-clock enable gap after edge 10.
    for (int i = 0; i < 10; i++) step("dc", 1'b0, 1'b1, 1024, 2047, 512);
    for (int i = 0; i < 5; i++)  step("dc_gap", 1'b0, 1'b0, 1024, 2047, 512);
    for (int i = 0; i < 20; i++) step("dc", 1'b0, 1'b1, 1024, 2047, 512);
    check("dc_final", longint'(dout), 1534);
    check("dc_final_valid", longint'(dout_valid), 1);

    step("rst_mid", 1'b1, 1'b1, 1024, 2047, 512);
    for (int i = 0; i < 20; i++) step("rst_mid", 1'b0, 1'b1, 0, 2047, 512);
    check("rst_mid_final", longint'(dout), -512);

    for (int i = 0; i < 24; i++)
      step("square", 1'b0, 1'b1, (i % 2 == 0) ? 1023 : -1024,
           (i % 2 == 0) ? 2047 : -2047, 0);
    check("square_final", longint'(dout), 2045);

    for (int i = 0; i < 22; i++) step("sat_hi", 1'b0, 1'b1, 2047, 2047, -2048);
    check("sat_hi_final", longint'(dout), 2047);
    for (int i = 0; i < 22; i++) step("sat_lo", 1'b0, 1'b1, -2048, 2047, 2047);
    check("sat_lo_final", longint'(dout), -2048);

    sh = rnd_s(DW);
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 20 == 0) sh = rnd_s(DW);
      step("rand", 1'($urandom % 60 == 0), 1'($urandom % 5 != 0),
           rnd_s(DW+1), rnd_s(DW), sh);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/am_demodulator.md
Name: am_demodulator

Overview:
- Coherent AM demodulator, the receive-side counterpart of the AM modulator in the DAC signal chain.
- Multiplies the received AM sample by the same carrier and low-passes the product with an N-tap boxcar (running sum over a circular buffer).
- Rescales the result by 2 and removes the DC offset a0, recovering M*m[n] in Q1.FW.
- Sits after the modulator/channel in loopback, or after the ADC front end.

Parameters:
- DW, 12, carrier/base/output width; FW = DW-1 fraction bits (local, not overridable)
- LOG2N, 4, log2 of boxcar length N = 2^LOG2N; legal range 1..8

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- en  input  1  sample-rate enable; all state advances only on clk edges with en=1
- carr  input  DW  signed carrier, Q1.FW, phase-aligned with the modulator's carrier
- modin  input  DW+1  signed AM sample, Q2.FW
- shift  input  DW  signed DC offset a0 to remove, Q1.FW; treated as quasi-static
- dout  output  DW  signed demodulated M*m[n], Q1.FW
- dout_valid  output  1  high once the boxcar window holds only post-reset samples

Behaviour:
- Reset: synchronous, active-high, on clk. Clears all pipeline registers, every buffer entry, accumulator, write pointer, fill counter, dout=0 and dout_valid=0. rst overrides en. Reset mid-stream discards all history; no stale sample may contribute afterwards.
- en=0: every register, buffer entry and counter holds. Latency and valid timing count en-qualified edges only.
- S1: prod (2*DW+1 bits, signed) <= modin*carr, full precision.
- S2: mix (DW+1 bits) <= prod[2*DW-1:DW-1]. This is a floor truncation to Q2.FW; the top bit is dropped, and the lossless range is |modin*carr| < 2.
- S3 (boxcar):
  - acc (DW+1+LOG2N bits) <= acc + mix - buf[wr_ptr].
  - buf[wr_ptr] <= mix.
  - wr_ptr <= wr_ptr+1, wrapping N-1 -> 0.
  - acc is exact, with no overflow for any input sequence.
- S4 (output):
  - diff = (acc >>> (LOG2N-1)) - sign-extended shift, computed at DW+LOG2N+2 bits. The shift is arithmetic and equals 2*mean.
  - dout <= diff saturated to [-2^(DW-1), 2^(DW-1)-1].
- Latency: modin accepted on en-edge k first affects dout on en-edge k+3. dout at edge j reflects the samples from edges j-N-2 .. j-3.
- Valid:
  - A fill counter counts en-edges after reset, saturating at N+3.
  - dout_valid is registered and rises on the (N+3)th en-edge after reset; it stays 1 until rst.
  - While dout_valid=0, dout still updates from the partially filled window, and consumers ignore it.
- Counter saturation: the counter stops at N+3 and never wraps, so dout_valid cannot drop on long runs.
- Simultaneous rst and en: reset wins, and no sample is captured on that edge.
- shift changes take effect in S4 on the next en-edge, with no pipeline alignment.

Test Plan (DW=12, LOG2N=4, N=16, 1.0=2048):
- Reset: hold rst 3 clk with random inputs -> dout=0, dout_valid=0. Release, en=1 continuously -> dout_valid first 1 on the 19th en-edge.
- DC carrier: carr=2047, modin=1024, shift=512 -> mix=1023, steady acc=16368, dout=1534 from edge 19 onward.
- Square carrier: carr alternates +2047/-2047, modin alternates +1023/-1024 in phase, shift=0 -> mix alternates 1022/1023, steady dout=2045.
- Saturation:
  - modin=2047, carr=2047, shift=-2048 -> diff=6140, dout=2047.
  - modin=-2048, carr=2047, shift=2047 -> mix=-2047, diff=-6141, dout=-2048.
- Enable gating: in the DC-carrier run, drop en for 5 clk at edge 10 -> dout/dout_valid frozen during the gap. dout_valid rises 5 clk later than the continuous run, and the final dout is again 1534.
- Reset mid-stream: after valid, with dout=1534, pulse rst 1 clk, then apply modin=0 -> dout=-512 (only -shift) on every edge, with no residual of the old window; dout_valid=0 until the 19th en-edge after release.
